// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory arbiter.
// Arbiter priority state and default bus widths.
package dmem_pkg;

  typedef enum logic {
    PRI_CORE,
    PRI_LOADER
  } arb_state_t;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 8;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: core vs loader/debug port.
// Core owns priority until the loader has starved for MAX_WAIT cycles.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,

  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,

  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dat_in,
  input  logic [DATA_W-1:0] mem_dat_out
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  arb_state_t  state, state_nxt;
  logic [3:0]  wait_cnt, wait_nxt;
  logic        core_rv_q, ld_rv_q;

  // Grants are killed during reset so a reset cycle never writes memory
  always_comb begin
    core_gnt = 1'b0;
    ld_gnt   = 1'b0;
    if (!reset) begin
      if (core_req && ld_req) begin
        if (state == PRI_LOADER) ld_gnt = 1'b1;
        else                     core_gnt = 1'b1;
      end else begin
        core_gnt = core_req;
        ld_gnt   = ld_req;
      end
    end
  end

  always_comb begin
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    mem_dat_in = '0;
    unique case (1'b1)
      core_gnt: begin
        mem_wr_en  = core_we;
        mem_addr   = core_addr;
        mem_dat_in = core_wdata;
      end
      ld_gnt: begin
        mem_wr_en  = ld_we;
        mem_addr   = ld_addr;
        mem_dat_in = ld_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    wait_nxt  = wait_cnt;
    state_nxt = state;
    if (ld_gnt) begin
      wait_nxt = '0;
    end else if (ld_req && (wait_cnt < WAIT_MAX)) begin
      wait_nxt = wait_cnt + 4'd1;
    end
    unique case (state)
      PRI_CORE: begin
        if (wait_nxt == WAIT_MAX) state_nxt = PRI_LOADER;
      end
      PRI_LOADER: begin
        if (ld_gnt) state_nxt = PRI_CORE;
      end
      default: state_nxt = PRI_CORE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PRI_CORE;
      wait_cnt   <= '0;
      core_rv_q  <= 1'b0;
      ld_rv_q    <= 1'b0;
      core_rdata <= '0;
      ld_rdata   <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      core_rv_q <= core_gnt && !core_we;
      ld_rv_q   <= ld_gnt && !ld_we;
      if (core_gnt && !core_we) core_rdata <= mem_dat_out;
      if (ld_gnt && !ld_we)     ld_rdata   <= mem_dat_out;
    end
  end

  // A read issued just before reset must not surface as rvalid in the reset cycle
  assign core_rvalid = core_rv_q && !reset;
  assign ld_rvalid   = ld_rv_q && !reset;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, directed sequences, random vs model.
// Memory array lives here, as it does outside the arbiter in the SoC.
module tb_dmem_arbiter;

  localparam int MAXW = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       core_req, core_we, core_gnt, core_rvalid;
  logic [7:0] core_addr, core_wdata, core_rdata;
  logic       ld_req, ld_we, ld_gnt, ld_rvalid;
  logic [7:0] ld_addr, ld_wdata, ld_rdata;
  logic       mem_wr_en;
  logic [7:0] mem_addr, mem_dat_in, mem_dat_out;

  logic [7:0] tb_mem [256];
  logic [7:0] ref_mem [256];

  int tests = 0;
  int fails = 0;

  bit         m_pri_ld;
  int         m_wait;
  bit         m_crv, m_lrv;
  logic [7:0] m_crd, m_lrd;

  bit         obs_cg, obs_lg, obs_we, obs_crv, obs_lrv;
  logic [7:0] obs_crd;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_dat_in(mem_dat_in), .mem_dat_out(mem_dat_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr_en) tb_mem[mem_addr] <= mem_dat_in;
  end
  assign mem_dat_out = tb_mem[mem_addr];

  typedef struct {
    bit         cr, cw;
    logic [7:0] ca, cd;
    bit         lr, lw;
    logic [7:0] la, ld;
    bit         rst;
    bit         e_cg, e_lg, e_we;
    logic [7:0] e_addr, e_din;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp,
               $time);
    end
  endtask

  task automatic drive(input bit cr, cw, input logic [7:0] ca, cd,
                       input bit lr, lw, input logic [7:0] la, ld,
                       input bit rst);
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    ld_req = lr; ld_we = lw; ld_addr = la; ld_wdata = ld;
    reset = rst;
  endtask

  task automatic model_reset();
    m_pri_ld = 0; m_wait = 0;
    m_crv = 0; m_lrv = 0; m_crd = 0; m_lrd = 0;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    model_reset();
  endtask

  // One cycle: drive, compare against the model, advance model, clock
  task automatic step(input bit cr, cw, input logic [7:0] ca, cd,
                      input bit lr, lw, input logic [7:0] la, ld,
                      input bit rst);
    bit         ecg, elg, ewe;
    logic [7:0] ea, ed;
    drive(cr, cw, ca, cd, lr, lw, la, ld, rst);
    #3;
    ecg = 0; elg = 0;
    if (!rst) begin
      if (cr && lr) begin
        elg = m_pri_ld;
        ecg = !m_pri_ld;
      end else begin
        ecg = cr;
        elg = lr;
      end
    end
    ewe = ecg ? cw : (elg ? lw : 1'b0);
    ea  = ecg ? ca : (elg ? la : 8'h00);
    ed  = ecg ? cd : (elg ? ld : 8'h00);
    check("core_gnt", 32'(core_gnt), 32'(ecg));
    check("ld_gnt", 32'(ld_gnt), 32'(elg));
    check("mem_wr_en", 32'(mem_wr_en), 32'(ewe));
    check("mem_addr", 32'(mem_addr), 32'(ea));
    check("mem_dat_in", 32'(mem_dat_in), 32'(ed));
    check("core_rvalid", 32'(core_rvalid), 32'(m_crv && !rst));
    check("ld_rvalid", 32'(ld_rvalid), 32'(m_lrv && !rst));
    check("core_rdata", 32'(core_rdata), 32'(m_crd));
    check("ld_rdata", 32'(ld_rdata), 32'(m_lrd));
    obs_cg = core_gnt; obs_lg = ld_gnt; obs_we = mem_wr_en;
    obs_crv = core_rvalid; obs_lrv = ld_rvalid; obs_crd = core_rdata;
    if (rst) begin
      model_reset();
    end else begin
      m_crv = ecg && !cw;
      m_lrv = elg && !lw;
      if (m_crv) m_crd = ref_mem[ca];
      if (m_lrv) m_lrd = ref_mem[la];
      if (ecg && cw) ref_mem[ca] = cd;
      if (elg && lw) ref_mem[la] = ld;
      if (elg) begin
        m_wait = 0;
        m_pri_ld = 0;
      end else if (lr) begin
        if (m_wait < MAXW) m_wait++;
        if (m_wait == MAXW) m_pri_ld = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  vec_t vecs [8];
  bit   exp_lg [6];

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 8'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[5] = 8'h3C;
    ref_mem[5] = 8'h3C;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;

    vecs[0] = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0, 0,0,0,8'h00,8'h00};
    vecs[1] = '{1,0,8'h05,8'h11, 0,0,8'h00,8'h00, 0, 1,0,0,8'h05,8'h11};
    vecs[2] = '{1,1,8'h22,8'h77, 0,0,8'h00,8'h00, 0, 1,0,1,8'h22,8'h77};
    vecs[3] = '{0,0,8'h33,8'h44, 1,1,8'h60,8'h5A, 0, 0,1,1,8'h60,8'h5A};
    vecs[4] = '{1,0,8'h30,8'h01, 1,1,8'h31,8'h99, 0, 1,0,0,8'h30,8'h01};
    vecs[5] = '{0,0,8'h00,8'h00, 1,1,8'h10,8'hA5, 1, 0,0,0,8'h00,8'h00};
    vecs[6] = '{0,0,8'h00,8'h00, 1,0,8'h40,8'h02, 0, 0,1,0,8'h40,8'h02};
    vecs[7] = '{0,1,8'h12,8'h34, 0,1,8'h56,8'h78, 0, 0,0,0,8'h00,8'h00};

    foreach (vecs[i]) begin
      do_reset();
      drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
            vecs[i].lr, vecs[i].lw, vecs[i].la, vecs[i].ld, vecs[i].rst);
      #3;
      check($sformatf("vec%0d_core_gnt", i), 32'(core_gnt), 32'(vecs[i].e_cg));
      check($sformatf("vec%0d_ld_gnt", i), 32'(ld_gnt), 32'(vecs[i].e_lg));
      check($sformatf("vec%0d_wr_en", i), 32'(mem_wr_en), 32'(vecs[i].e_we));
      check($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
      check($sformatf("vec%0d_din", i), 32'(mem_dat_in), 32'(vecs[i].e_din));
      if (vecs[i].e_we) ref_mem[vecs[i].e_addr] = vecs[i].e_din;
      @(posedge clk); #1;
    end
    do_reset();

    // core-only read of 0x05 holding 0x3C
    step(1, 0, 8'h05, 0, 0, 0, 0, 0, 0);
    check("rd05_gnt", 32'(obs_cg), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rd05_rvalid", 32'(obs_crv), 32'd1);
    check("rd05_rdata", 32'(obs_crd), 32'h3C);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rd05_rvalid_drop", 32'(obs_crv), 32'd0);

    // loader write then core read of the same address
    step(0, 0, 0, 0, 1, 1, 8'h10, 8'hA5, 0);
    step(1, 0, 8'h10, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("raw10_rdata", 32'(obs_crd), 32'hA5);

    // reset with a pending read and a loader write request
    step(1, 0, 8'h05, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 8'h20, 8'hEE, 1);
    check("rst_wr_en", 32'(obs_we), 32'd0);
    check("rst_ld_gnt", 32'(obs_lg), 32'd0);
    check("rst_rvalid", 32'(obs_crv), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("post_rst_crv", 32'(obs_crv), 32'd0);
    check("post_rst_lrv", 32'(obs_lrv), 32'd0);
    check("post_rst_crd", 32'(obs_crd), 32'd0);

    // both requesting continuously: 4 core grants, loader, core
    exp_lg = '{0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 8'(i), 0, 1, 0, 8'(i + 8), 0, 0);
      check($sformatf("fair_c%0d_ld", i + 1), 32'(obs_lg), 32'(exp_lg[i]));
      check($sformatf("fair_c%0d_core", i + 1), 32'(obs_cg),
            32'(!exp_lg[i]));
    end

    // loader withdraws at wait_cnt=2, counting resumes from 2
    do_reset();
    step(1, 0, 8'h01, 0, 1, 0, 8'h02, 0, 0);
    step(1, 0, 8'h01, 0, 1, 0, 8'h02, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 8'h03, 0, 0, 0, 0, 0, 0);
    step(1, 0, 8'h01, 0, 1, 0, 8'h02, 0, 0);
    check("resume_c1_ld", 32'(obs_lg), 32'd0);
    step(1, 0, 8'h01, 0, 1, 0, 8'h02, 0, 0);
    check("resume_c2_ld", 32'(obs_lg), 32'd0);
    step(1, 0, 8'h01, 0, 1, 0, 8'h02, 0, 0);
    check("resume_c3_ld", 32'(obs_lg), 32'd1);

    // randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
           8'($urandom_range(0, 15)), 8'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0,
           8'($urandom_range(0, 15)), 8'($urandom),
           $urandom_range(0, 49) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter SHALL be: ADDR_W, 8, memory address width.
REQ-002 Parameter SHALL be: DATA_W, 8, memory data width.
REQ-003 Parameter SHALL be: MAX_WAIT, 4, loader wait cycles before it gains priority (range 1..15).
REQ-004 Port SHALL be: clk  input  1  clock; all state updates on its rising edge.
REQ-005 Port SHALL be: reset  input  1  reset, synchronous, active-high.
REQ-006 Port SHALL be: core_req  input  1  core access request, held until core_gnt.
REQ-007 Port SHALL be: core_we  input  1  core write (1) / read (0).
REQ-008 Port SHALL be: core_addr  input  ADDR_W  core address.
REQ-009 Port SHALL be: core_wdata  input  DATA_W  core write data.
REQ-010 Port SHALL be: core_gnt  output  1  core access issued this cycle.
REQ-011 Port SHALL be: core_rvalid  output  1  core read data valid.
REQ-012 Port SHALL be: core_rdata  output  DATA_W  core read data.
REQ-013 Ports SHALL be: ld_req, ld_we, ld_addr, ld_wdata, ld_gnt, ld_rvalid, ld_rdata, with the same directions, widths and meanings as the core set, for the loader/debug requester.
REQ-014 Port SHALL be: mem_wr_en  output  1  memory write enable.
REQ-015 Port SHALL be: mem_addr  output  ADDR_W  memory address.
REQ-016 Port SHALL be: mem_dat_in  output  DATA_W  memory write data.
REQ-017 Port SHALL be: mem_dat_out  input  DATA_W  memory combinational read data.

Function
REQ-018 Grants SHALL be combinational from requests and priority state; at most one of core_gnt/ld_gnt is high per cycle; a gnt is never high without its req.
REQ-019 Arbiter states SHALL be PRI_CORE and PRI_LOADER; on conflict (both req), the state's owner wins; an uncontested request is always granted in the same cycle.
REQ-020 wait_cnt SHALL increment, saturating at MAX_WAIT, each cycle ld_req=1 and ld_gnt=0; it SHALL clear on ld_gnt.
REQ-021 Transition PRI_CORE->PRI_LOADER SHALL occur at the edge where wait_cnt becomes MAX_WAIT; PRI_LOADER->PRI_CORE SHALL occur at the edge following ld_gnt.
REQ-022 mem_addr, mem_dat_in and mem_wr_en (=granted we) SHALL be muxed from the granted requester; with no grant, all three SHALL be 0.
REQ-023 A granted read SHALL capture mem_dat_out at the grant edge; the requester's rvalid SHALL be high for exactly the next cycle with rdata holding the captured value; rdata SHALL hold until the next read of that requester.
REQ-024 A granted write SHALL complete at the grant edge; no rvalid SHALL be produced.
REQ-025 Back-to-back grants SHALL be sustained: one access per cycle, zero bubbles.
REQ-026 A write then a read of the same address by either requester in consecutive cycles SHALL return the newly written data.
REQ-027 A request withdrawn before grant SHALL be dropped without error; wait_cnt SHALL then hold its value.

Reset
REQ-028 While reset=1: core_gnt, ld_gnt, mem_wr_en SHALL be 0 (combinationally forced), so no memory write occurs in a reset cycle.
REQ-029 At the edge with reset=1: state SHALL be PRI_CORE, wait_cnt 0, both rvalid 0, both rdata 0.
REQ-030 A read granted in the cycle before reset asserts SHALL NOT produce rvalid after reset.

Structure
REQ-031 Package dmem_pkg SHALL hold the arb_state_t enum {PRI_CORE, PRI_LOADER} and the constants DMEM_ADDR_W=8, DMEM_DATA_W=8.
REQ-032 No sub-module is required; the memory array SHALL be instantiated outside this block and connected through the mem_* ports.

Verification
REQ-033 Core-only read of address 0x05 holding 0x3C: core_gnt is high in the same cycle; the next cycle core_rvalid=1 and core_rdata=0x3C.
REQ-034 Both requesters hold req continuously with MAX_WAIT=4: the core is granted for 4 cycles, ld_gnt is high in cycle 5, and the core is granted again in cycle 6.
REQ-035 Loader writes 0xA5 to 0x10, then the core reads 0x10 in the next cycle: core_rdata=0xA5.
REQ-036 Reset is asserted in a cycle where ld_req=1 and ld_we=1: mem_wr_en stays 0, and after reset state=PRI_CORE, wait_cnt=0, and both rvalid=0.
REQ-037 Idle cycle (no requests): mem_addr=0, mem_dat_in=0, mem_wr_en=0, both gnt=0.
REQ-038 ld_req is withdrawn when wait_cnt=2 and reasserted later: counting resumes from 2.
